// File: rtl/gpu_pkg.sv
// Shared types and defaults for the GPU VRAM access path.
// Imported by the arbiter and its round-robin picker.
package gpu_pkg;

  localparam int BURST_MAX_DEF    = 16;
  localparam int STARVE_LIMIT_DEF = 32;

  typedef struct packed {
    logic        we;
    logic [8:0]  line;
    logic [11:0] col;
    logic [3:0]  mode;
    logic [23:0] wdata;
  } vram_req_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_DISP,
    OWN_DRAW,
    OWN_DMA
  } vram_owner_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    TURN
  } arb_state_e;

endpackage

// File: rtl/vram_rr_pick.sv
// Next-owner selection: starved draw/dma first, then disp,
// then the draw/dma pair in round-robin order.
module vram_rr_pick
  import gpu_pkg::*;
(
  input  logic [2:0]  req,
  input  logic [1:0]  starve,
  input  logic        rr_dma,
  output vram_owner_e pick
);

  // req = {dma, draw, disp}; starve = {dma, draw}
  always_comb begin
    pick = OWN_NONE;
    if (starve[0] && starve[1])
      pick = rr_dma ? OWN_DMA : OWN_DRAW;
    else if (starve[0])
      pick = OWN_DRAW;
    else if (starve[1])
      pick = OWN_DMA;
    else if (req[0])
      pick = OWN_DISP;
    else if (req[1] && req[2])
      pick = rr_dma ? OWN_DMA : OWN_DRAW;
    else if (req[1])
      pick = OWN_DRAW;
    else if (req[2])
      pick = OWN_DMA;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-owner VRAM port scheduler for disp, draw and dma,
// with burst limits, starvation promotion and bus turnaround.
module vram_arbiter
  import gpu_pkg::*;
#(
  parameter int BURST_MAX    = BURST_MAX_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk_53_2MHz,
  input  logic        rst,
  input  logic        disp_req,
  input  logic        disp_we,
  input  logic [8:0]  disp_line,
  input  logic [11:0] disp_col,
  input  logic [3:0]  disp_mode,
  input  logic        draw_req,
  input  logic        draw_we,
  input  logic [8:0]  draw_line,
  input  logic [11:0] draw_col,
  input  logic [3:0]  draw_mode,
  input  logic [23:0] draw_wdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [8:0]  dma_line,
  input  logic [11:0] dma_col,
  input  logic [3:0]  dma_mode,
  input  logic [23:0] dma_wdata,
  output logic        disp_gnt,
  output logic        draw_gnt,
  output logic        dma_gnt,
  output logic        disp_rvalid,
  output logic        draw_rvalid,
  output logic        dma_rvalid,
  output logic [23:0] rdata,
  output logic [8:0]  vram_line,
  output logic [11:0] vram_col,
  output logic [3:0]  vram_mode,
  output logic        vram_we,
  output logic        vram_re,
  inout  wire  [23:0] vram_data
);

  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int WW = $clog2(STARVE_LIMIT + 1);
  localparam logic [BW-1:0] BMAX = BW'(BURST_MAX);
  localparam logic [WW-1:0] SLIM = WW'(STARVE_LIMIT);

  arb_state_e  state_q;
  vram_owner_e own_q;
  vram_owner_e rd_own_q;
  vram_owner_e pick;
  vram_owner_e nxt_own;
  logic [BW-1:0] burst_q;
  logic [WW-1:0] draw_wait_q;
  logic [WW-1:0] dma_wait_q;
  logic [23:0] wdata_q;
  logic        rr_q;
  logic        rr_eff;

  vram_req_t disp_r;
  vram_req_t draw_r;
  vram_req_t dma_r;
  vram_req_t sel;

  logic own_req;
  logic rr_own;
  logic starve_draw;
  logic starve_dma;
  logic preempt;
  logic active;
  logic keep;
  logic turn;
  logic issue;
  logic unused_disp_we;

  // display only ever reads
  assign unused_disp_we = disp_we;
  assign disp_r = {1'b0, disp_line, disp_col,
                   disp_mode, 24'd0};
  assign draw_r = {draw_we, draw_line, draw_col,
                   draw_mode, draw_wdata};
  assign dma_r  = {dma_we, dma_line, dma_col,
                   dma_mode, dma_wdata};

  assign starve_draw = draw_req && draw_wait_q == SLIM;
  assign starve_dma  = dma_req && dma_wait_q == SLIM;

  always_comb begin
    own_req = 1'b0;
    unique case (own_q)
      OWN_DISP: own_req = disp_req;
      OWN_DRAW: own_req = draw_req;
      OWN_DMA:  own_req = dma_req;
      default:  own_req = 1'b0;
    endcase
  end

  assign rr_own = own_q == OWN_DRAW
               || own_q == OWN_DMA;
  assign preempt = (rr_own && disp_req)
                || (own_q == OWN_DISP
                    && (starve_draw || starve_dma));
  assign active = state_q != IDLE;
  assign keep = active && own_req
             && burst_q < BMAX && !preempt;

  // flip only when a draw/dma owner that issued beats lets go
  assign rr_eff = (active && !keep && rr_own
                   && burst_q != '0)
                ? (own_q == OWN_DRAW) : rr_q;

  vram_rr_pick u_pick (
    .req    ({dma_req, draw_req, disp_req}),
    .starve ({starve_dma, starve_draw}),
    .rr_dma (rr_eff),
    .pick   (pick)
  );

  assign nxt_own = keep ? own_q : pick;

  always_comb begin
    sel = '0;
    unique case (nxt_own)
      OWN_DISP: sel = disp_r;
      OWN_DRAW: sel = draw_r;
      OWN_DMA:  sel = dma_r;
      default:  sel = '0;
    endcase
  end

  // after IDLE or TURN the bus is already quiet for a cycle
  assign turn = state_q == ACCESS
             && nxt_own != OWN_NONE
             && sel.we != vram_we;
  assign issue = nxt_own != OWN_NONE && !turn;

  always_ff @(posedge clk_53_2MHz or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      own_q   <= OWN_NONE;
      burst_q <= '0;
      rr_q    <= 1'b0;
    end else begin
      if (nxt_own == OWN_NONE)
        state_q <= IDLE;
      else if (turn)
        state_q <= TURN;
      else
        state_q <= ACCESS;
      own_q   <= nxt_own;
      burst_q <= keep ? burst_q + BW'(issue)
                      : BW'(issue);
      rr_q    <= rr_eff;
    end
  end

  always_ff @(posedge clk_53_2MHz or posedge rst) begin
    if (rst) begin
      draw_wait_q <= '0;
      dma_wait_q  <= '0;
    end else begin
      if (issue && nxt_own == OWN_DRAW)
        draw_wait_q <= '0;
      else if (draw_req && draw_wait_q != SLIM)
        draw_wait_q <= draw_wait_q + 1'b1;
      if (issue && nxt_own == OWN_DMA)
        dma_wait_q <= '0;
      else if (dma_req && dma_wait_q != SLIM)
        dma_wait_q <= dma_wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk_53_2MHz or posedge rst) begin
    if (rst) begin
      vram_we   <= 1'b0;
      vram_re   <= 1'b0;
      vram_line <= '0;
      vram_col  <= '0;
      vram_mode <= '0;
      wdata_q   <= '0;
      disp_gnt  <= 1'b0;
      draw_gnt  <= 1'b0;
      dma_gnt   <= 1'b0;
      rd_own_q  <= OWN_NONE;
    end else begin
      vram_we  <= issue && sel.we;
      vram_re  <= issue && !sel.we;
      if (issue) begin
        vram_line <= sel.line;
        vram_col  <= sel.col;
        vram_mode <= sel.mode;
        wdata_q   <= sel.wdata;
      end
      disp_gnt <= issue && nxt_own == OWN_DISP;
      draw_gnt <= issue && nxt_own == OWN_DRAW;
      dma_gnt  <= issue && nxt_own == OWN_DMA;
      rd_own_q <= (issue && !sel.we)
                ? nxt_own : OWN_NONE;
    end
  end

  always_ff @(posedge clk_53_2MHz or posedge rst) begin
    if (rst) begin
      rdata       <= '0;
      disp_rvalid <= 1'b0;
      draw_rvalid <= 1'b0;
      dma_rvalid  <= 1'b0;
    end else begin
      if (rd_own_q != OWN_NONE)
        rdata <= vram_data;
      disp_rvalid <= rd_own_q == OWN_DISP;
      draw_rvalid <= rd_own_q == OWN_DRAW;
      dma_rvalid  <= rd_own_q == OWN_DMA;
    end
  end

  assign vram_data = vram_we ? wdata_q : 24'bz;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: per-cycle owner traces
// checked against hand-derived strings.
module tb_vram_arbiter;
  import gpu_pkg::*;

  logic        clk_53_2MHz;
  logic        rst;
  logic        disp_req, disp_we;
  logic [8:0]  disp_line;
  logic [11:0] disp_col;
  logic [3:0]  disp_mode;
  logic        draw_req, draw_we;
  logic [8:0]  draw_line;
  logic [11:0] draw_col;
  logic [3:0]  draw_mode;
  logic [23:0] draw_wdata;
  logic        dma_req, dma_we;
  logic [8:0]  dma_line;
  logic [11:0] dma_col;
  logic [3:0]  dma_mode;
  logic [23:0] dma_wdata;
  logic        disp_gnt, draw_gnt, dma_gnt;
  logic        disp_rvalid, draw_rvalid, dma_rvalid;
  logic [23:0] rdata;
  logic [8:0]  vram_line;
  logic [11:0] vram_col;
  logic [3:0]  vram_mode;
  logic        vram_we, vram_re;
  wire  [23:0] vram_data;

  int nvec = 0;
  int nerr = 0;

  int          rem[3];
  bit          hold[3];
  bit          req_b[3];
  bit          we_b[3];
  logic [8:0]  line_b[3];
  logic [11:0] col_b[3];
  logic [3:0]  mode_b[3];
  logic [23:0] wd_b[3];
  logic [23:0] zz;

  vram_arbiter dut (
    .clk_53_2MHz (clk_53_2MHz),
    .rst         (rst),
    .disp_req    (disp_req),
    .disp_we     (disp_we),
    .disp_line   (disp_line),
    .disp_col    (disp_col),
    .disp_mode   (disp_mode),
    .draw_req    (draw_req),
    .draw_we     (draw_we),
    .draw_line   (draw_line),
    .draw_col    (draw_col),
    .draw_mode   (draw_mode),
    .draw_wdata  (draw_wdata),
    .dma_req     (dma_req),
    .dma_we      (dma_we),
    .dma_line    (dma_line),
    .dma_col     (dma_col),
    .dma_mode    (dma_mode),
    .dma_wdata   (dma_wdata),
    .disp_gnt    (disp_gnt),
    .draw_gnt    (draw_gnt),
    .dma_gnt     (dma_gnt),
    .disp_rvalid (disp_rvalid),
    .draw_rvalid (draw_rvalid),
    .dma_rvalid  (dma_rvalid),
    .rdata       (rdata),
    .vram_line   (vram_line),
    .vram_col    (vram_col),
    .vram_mode   (vram_mode),
    .vram_we     (vram_we),
    .vram_re     (vram_re),
    .vram_data   (vram_data)
  );

  function automatic logic [23:0] mem_fn(
    logic [8:0] l, logic [11:0] c);
    if (l == 9'd5 && c == 12'h010)
      return 24'hABCDEF;
    return {3'b101, l, c};
  endfunction

  // VRAM model drives the bus only during read beats
  assign vram_data = vram_re
                   ? mem_fn(vram_line, vram_col) : 24'bz;

  initial clk_53_2MHz = 1'b0;
  always #5 clk_53_2MHz = ~clk_53_2MHz;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic drive();
    disp_req   = req_b[0];
    draw_req   = req_b[1];
    dma_req    = req_b[2];
    disp_we    = 1'b1;
    draw_we    = we_b[1];
    dma_we     = we_b[2];
    disp_line  = line_b[0];
    draw_line  = line_b[1];
    dma_line   = line_b[2];
    disp_col   = col_b[0];
    draw_col   = col_b[1];
    dma_col    = col_b[2];
    disp_mode  = mode_b[0];
    draw_mode  = mode_b[1];
    dma_mode   = mode_b[2];
    draw_wdata = wd_b[1];
    dma_wdata  = wd_b[2];
  endtask

  task automatic setr(int k, int n, bit h, bit w,
                      logic [8:0] l, logic [11:0] c,
                      logic [23:0] d);
    rem[k]    = n;
    hold[k]   = h;
    we_b[k]   = w;
    line_b[k] = l;
    col_b[k]  = c;
    mode_b[k] = 4'(k + 3);
    wd_b[k]   = d;
    req_b[k]  = n > 0;
  endtask

  task automatic do_reset();
    for (int k = 0; k < 3; k++)
      setr(k, 0, 0, 0, 9'd0, 12'd0, 24'd0);
    drive();
    rst = 1'b1;
    repeat (2) @(negedge clk_53_2MHz);
    rst = 1'b0;
  endtask

  // exp: one char per cycle, P/D/M = granted owner, . = none
  task automatic run(string tn, string exp, int trig);
    string codes = "PDM";
    byte code;
    int idx, pidx, ndraw;
    bit pread, dir;
    logic [23:0] pdata;
    logic [2:0] g, rv, erv;
    string t;
    pread = 0;
    pidx  = 0;
    pdata = '0;
    ndraw = 0;
    drive();
    for (int i = 0; i < exp.len(); i++) begin
      @(negedge clk_53_2MHz);
      t = $sformatf("%s.c%0d", tn, i + 1);
      g = {dma_gnt, draw_gnt, disp_gnt};
      rv = {dma_rvalid, draw_rvalid, disp_rvalid};
      idx = disp_gnt ? 0 : draw_gnt ? 1
          : dma_gnt ? 2 : -1;
      code = idx >= 0 ? codes[idx] : 8'h2e;
      chk({t, ".own"}, 32'(code), 32'(exp[i]));
      chk({t, ".gnt1"}, 32'($countones(g) > 1), 0);
      chk({t, ".wexre"}, 32'(vram_we & vram_re), 0);
      erv = pread ? 3'(1 << pidx) : 3'b000;
      chk({t, ".rvalid"}, 32'(rv), 32'(erv));
      if (pread)
        chk({t, ".rdata"}, 32'(rdata), 32'(pdata));
      if (idx >= 0) begin
        dir = idx == 0 ? 1'b0 : we_b[idx];
        chk({t, ".dir"}, 32'({vram_we, vram_re}),
            32'(dir ? 2'b10 : 2'b01));
        chk({t, ".line"}, 32'(vram_line),
            32'(line_b[idx]));
        chk({t, ".col"}, 32'(vram_col),
            32'(col_b[idx]));
        chk({t, ".mode"}, 32'(vram_mode),
            32'(mode_b[idx]));
        if (dir)
          chk({t, ".wdata"}, 32'(vram_data),
              32'(wd_b[idx]));
        pread = !dir;
        pidx  = idx;
        pdata = mem_fn(line_b[idx], col_b[idx]);
        rem[idx]--;
        col_b[idx]++;
        if (idx == 1)
          ndraw++;
      end else begin
        pread = 0;
        chk({t, ".idle"}, 32'({vram_we, vram_re}), 0);
        chk({t, ".busz"}, 32'(vram_data), 32'(zz));
      end
      for (int k = 0; k < 3; k++)
        req_b[k] = rem[k] > 0 && !(g[k] && !hold[k]);
      if (trig > 0 && idx == 1 && ndraw == trig) begin
        rem[0]   = 1;
        req_b[0] = 1;
      end
      drive();
    end
  endtask

  function automatic string rep(string c, int n);
    string s = "";
    for (int i = 0; i < n; i++)
      s = {s, c};
    return s;
  endfunction

  initial begin
    zz  = 'z;
    rst = 1'b1;
    for (int k = 0; k < 3; k++)
      setr(k, 0, 0, 0, 9'd0, 12'd0, 24'd0);
    drive();
    #2;
    chk("rst.gnt", 32'({disp_gnt, draw_gnt, dma_gnt}), 0);
    chk("rst.rv", 32'({disp_rvalid, draw_rvalid,
                        dma_rvalid}), 0);
    chk("rst.strb", 32'({vram_we, vram_re}), 0);
    chk("rst.rdata", 32'(rdata), 0);
    chk("rst.addr", 32'({vram_line, vram_col,
                          vram_mode}), 0);
    chk("rst.bus", 32'(vram_data), 32'(zz));

    do_reset();
    setr(1, 1, 0, 0, 9'd5, 12'h010, 24'd0);
    run("rd1", "D..", 0);
    chk("rd1.abcdef", 32'(rdata), 32'h00ABCDEF);

    do_reset();
    setr(1, 4, 0, 1, 9'd10, 12'h100, 24'hD1A0D1);
    setr(2, 4, 0, 1, 9'd20, 12'h200, 24'h0DA00A);
    run("wr8", {rep("DM", 4), "."}, 0);

    do_reset();
    setr(1, 20, 1, 0, 9'd30, 12'h000, 24'd0);
    setr(2, 1, 0, 0, 9'd31, 12'h040, 24'd0);
    run("b20", {rep("D", 16), "M", rep("D", 4), "."}, 0);

    do_reset();
    setr(0, 0, 1, 0, 9'd40, 12'h300, 24'd0);
    setr(1, 6, 1, 0, 9'd41, 12'h000, 24'd0);
    setr(2, 1, 0, 1, 9'd42, 12'h020, 24'h5A5A5A);
    run("pre", "DDDP.M.DDD.", 3);

    do_reset();
    setr(1, 1, 0, 1, 9'd50, 12'h001, 24'h123456);
    setr(2, 1, 0, 0, 9'd51, 12'h002, 24'd0);
    run("w2r", "D.M.", 0);

    do_reset();
    setr(0, 40, 1, 0, 9'd60, 12'h000, 24'd0);
    setr(2, 1, 0, 0, 9'd61, 12'h050, 24'd0);
    run("stv", {rep("P", 32), "M", rep("P", 8), "."}, 0);

    do_reset();
    setr(1, 1, 0, 0, 9'd5, 12'h010, 24'd0);
    drive();
    @(negedge clk_53_2MHz);
    chk("arst.pre_gnt", 32'(draw_gnt), 1);
    chk("arst.pre_re", 32'(vram_re), 1);
    #1 rst = 1'b1;
    #1;
    chk("arst.gnt", 32'(draw_gnt), 0);
    chk("arst.strb", 32'({vram_we, vram_re}), 0);
    chk("arst.addr", 32'({vram_line, vram_col,
                           vram_mode}), 0);
    chk("arst.bus", 32'(vram_data), 32'(zz));
    setr(1, 0, 0, 0, 9'd0, 12'd0, 24'd0);
    drive();
    @(negedge clk_53_2MHz);
    chk("arst.rv", 32'(draw_rvalid), 0);
    chk("arst.rdata", 32'(rdata), 0);
    rst = 1'b0;
    setr(1, 1, 0, 0, 9'd7, 12'h077, 24'd0);
    run("post", "D..", 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim still running");
    $fatal(1);
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-owner access scheduler for the GPU's 4-bit-granular VRAM array. It shares one VRAM port among three requesters: display scanout, the draw engine, and the CPU/DMA transfer unit. It issues at most one access per cycle, manages bus turnaround on the shared tristate data bus, and returns read data to the owning requester. It sits between the GPU requesters and the `vram` storage block, and is the only block that drives VRAM's line/col/mode/we/re.

## Interface
- `BURST_MAX`, default 16: maximum consecutive beats one requester may hold the port.
- `STARVE_LIMIT`, default 32: cycles draw/DMA may wait before they are promoted above display.
- `clk_53_2MHz`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `{disp,draw,dma}_req`  in  1  request; held with its fields until `_gnt`
- `{disp,draw,dma}_we`  in  1  1 = write, 0 = read (`disp_we` is ignored; display always reads)
- `{disp,draw,dma}_line`  in  9  VRAM line
- `{disp,draw,dma}_col`  in  12  column in access units
- `{disp,draw,dma}_mode`  in  4  access width code, passed through to VRAM
- `{draw,dma}_wdata`  in  24  write data
- `{disp,draw,dma}_gnt`  out  1  one-cycle pulse; the access was issued this cycle
- `{disp,draw,dma}_rvalid`  out  1  one-cycle pulse; `rdata` is valid for this owner
- `rdata`  out  24  registered read data, shared by all requesters
- `vram_line`  out  9,  `vram_col`  out  12,  `vram_mode`  out  4  VRAM address/mode
- `vram_we`, `vram_re`  out  1  VRAM strobes; never both high
- `vram_data`  inout  24  driven only while `vram_we`=1, otherwise `'z`

## Operation
- States:
  - IDLE: nothing is issued.
  - ACCESS: one beat is issued per cycle.
  - TURN: one dead cycle; `vram_we`=`vram_re`=0 and data is `'z`.
- Priority: `disp` beats the round-robin pair (`draw`, `dma`).
  - The round-robin pointer flips to the other requester after each ownership release.
- Promotion: a waiting draw/DMA requester whose wait counter reaches `STARVE_LIMIT` is served before `disp`, once.
  - Its counter then clears.
  - Counters count cycles with `req`=1 and no grant, saturate at `STARVE_LIMIT`, and clear on grant.
- Ownership persists while the owner keeps `req`=1, up to `BURST_MAX` beats, with one exception.
  - If `disp` requests while draw/DMA owns the port, ownership ends after the current beat.
  - After the owner's `req` drops, it is released at the next cycle boundary.
- Turnaround: a TURN cycle is inserted before any beat whose direction (read/write) differs from the previous issued beat.
  - This applies within one owner and across owners.
  - Same-direction owner switches are back-to-back with no TURN.
- Read capture:
  - `rdata` captures `vram_data` at the end of each read beat.
  - The owner's `rvalid` pulses in the following cycle.
  - `rdata` holds its value until the next read capture.
- Write: `vram_data` = the owner's `wdata` during the write beat only.
- `mode` and the address are passed through unmodified. Address legality is the requester's responsibility.

## Timing
- Reset values:
  - all `_gnt` and `_rvalid` = 0; `vram_we` = `vram_re` = 0; `vram_data` = `'z`.
  - `rdata` = 0; `vram_line` = `vram_col` = `vram_mode` = 0.
  - state = IDLE; round-robin pointer = draw; burst and starvation counters = 0.
- All outputs are registered.
- A request sampled high at edge t, with the port free, is issued in cycle t+1: `vram_*` are driven and `_gnt`=1.
  - Read data appears at t+2 with `rvalid`=1.
- Peak throughput is 1 beat per cycle with the same owner and same direction.
- A direction change costs exactly 1 cycle.
- Simultaneous requests from all three are granted `disp` first, then draw/DMA in round-robin order.
- A requester that drops `req` before `gnt` is treated as withdrawn. No beat is issued for it.
- Assertion of `rst` mid-beat:
  - The beat is aborted and no `rvalid` follows.
  - `vram_data` releases to `'z` asynchronously.
- `_gnt` and `_rvalid` for different requesters may be high in the same cycle. Example: draw `rvalid` alongside dma `gnt`.

## Structure
- `gpu_pkg` holds:
  - typedef `vram_req_t` {we, line[8:0], col[11:0], mode[3:0], wdata[23:0]}.
  - enum `vram_owner_e` {OWN_NONE, OWN_DISP, OWN_DRAW, OWN_DMA}.
  - enum `arb_state_e` {IDLE, ACCESS, TURN}.
  - default constants for `BURST_MAX` and `STARVE_LIMIT`.
- One combinational sub-module, `vram_rr_pick`. It takes the request vector, starvation flags and the round-robin pointer, and returns the next owner. It is unit-testable on its own.

## Test plan
- Draw reads (line 5, col 0x010) alone → `draw_gnt` in cycle 1, `vram_re`=1 with `vram_line`=5 and `vram_col`=0x010; `draw_rvalid` in cycle 2 with `rdata` = the preloaded 0xABCDEF.
- Draw and DMA both request 4 single-beat writes each → grants alternate draw, dma, draw, dma…; no TURN; 8 writes land in 8 consecutive cycles.
- Draw holds a read burst of 20 → exactly 16 beats, release, 4 further beats after re-arbitration. Adding DMA with a `disp` read at beat 3 → `disp` owns beat 4, after a TURN only if directions differ.
- Write beat followed by a read beat → exactly one cycle with `vram_we`=`vram_re`=0 and `vram_data`=`'z` between them; `vram_we` and `vram_re` are never both 1.
- `disp` requests continuously while DMA waits → DMA is granted on wait cycle 32, then `disp` resumes.
- `rst` asserted during a draw read beat → all outputs return to reset values within the same cycle; no `draw_rvalid`; a fresh request after `rst` deasserts is granted normally.
